vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Parameters
REQ-001 SHALL accept H_ACTIVE, default 200, visible pixels per line.
REQ-002 SHALL accept H_FP / H_SYNC / H_BP, defaults 10 / 32 / 22, horizontal porch and sync widths in pixels.
REQ-003 SHALL accept V_ACTIVE, default 600, visible lines per frame.
REQ-004 SHALL accept V_FP / V_SYNC / V_BP, defaults 1 / 4 / 23, vertical porch and sync widths in lines.
REQ-005 SHALL accept HS_POL / VS_POL, default 1 / 1, the asserted level of VGA_HS / VGA_VS.
REQ-006 SHALL accept CLK_DIV, default 5, with legal range 2..64; it is the number of CLOCK_50 cycles per pixel.
REQ-007 SHALL accept ADDR_W, default 17, and PIXEL_W, default 24, as framebuffer address and data widths; PIXEL_W is a multiple of 3.

Interface
REQ-008 CLOCK_50  in  1  sole clock; all logic on posedge.
REQ-009 RESET_N  in  1  asynchronous active-low reset.
REQ-010 MODE  in  2  source select: 0 framebuffer, 1 colour bars, 2 checkerboard, 3 black.
REQ-011 FB_ADDR  out  ADDR_W  framebuffer read address.
REQ-012 FB_DATA  in  PIXEL_W  framebuffer read data; valid one CLOCK_50 cycle after FB_ADDR changes.
REQ-013 VGA_R, VGA_G, VGA_B  out  PIXEL_W/3 each  colour to DAC.
REQ-014 VGA_HS, VGA_VS  out  1  syncs at the HS_POL/VS_POL polarity.
REQ-015 VGA_BLANK_N  out  1  high only during active video.
REQ-016 VGA_SYNC_N  out  1  tied 0; no sync-on-green.
REQ-017 VGA_CLK  out  1  DAC latch clock, one period per pixel.
REQ-018 FRAME_START  out  1  one CLOCK_50-cycle pulse when pixel (0,0) is output.

Function
REQ-019 Divider counts 0..CLK_DIV-1; pix_en is asserted in the cycle where count == CLK_DIV-1; no derived clock SHALL clock any register.
REQ-020 h_cnt counts 0..H_TOTAL-1 on pix_en, with H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, and wraps to 0.
REQ-021 v_cnt advances by one on the h_cnt wrap, counts 0..V_TOTAL-1 (V_TOTAL defined likewise), and wraps to 0; both counters wrap together at end of frame.
REQ-022 Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-023 HS is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
REQ-024 VS is asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, over whole lines.
REQ-025 FB_ADDR SHALL be generated incrementally, with no multiplier:
- +1 after each active pixel;
- reset to 0 at frame wrap;
- held during blanking;
- it never exceeds H_ACTIVE*V_ACTIVE-1.
REQ-026 FB_ADDR is registered on pix_en together with the counters, so FB_DATA is stable before the next pix_en.
REQ-027 Pipeline is two stages: counters/address, then output. The RGB, HS, VS and BLANK_N for counter position (h,v) SHALL all appear on the same pix_en, exactly 2 pix_en after the counters held (h,v).
REQ-028 Outside the active region, RGB SHALL be 0 irrespective of MODE.
REQ-029 MODE 1 SHALL produce 8 equal-width vertical bars, using bar index = (h_cnt*8)/H_ACTIVE via a precomputed-threshold comparison:
- component R is all-ones when bit2 of the index is set;
- component G is all-ones when bit1 is set;
- component B is all-ones when bit0 is set.
REQ-030 MODE 2 SHALL produce white where h_cnt[3] XOR v_cnt[3] is 1, else black.
REQ-031 MODE SHALL be sampled only at frame wrap (h_cnt = v_cnt = 0); mid-frame changes take effect on the next frame.
REQ-032 VGA_CLK SHALL be 0 for divider counts 0..CLK_DIV/2-1 and 1 otherwise; its rising edge falls mid-pixel after RGB is stable.
REQ-033 FRAME_START SHALL pulse on the CLOCK_50 cycle on which RGB for (0,0) updates.

Reset
REQ-034 While RESET_N = 0, the following SHALL be 0:
- divider, h_cnt, v_cnt, FB_ADDR;
- all pipeline registers, RGB;
- VGA_BLANK_N, VGA_CLK, FRAME_START.
REQ-035 While RESET_N = 0, VGA_HS = ~HS_POL, VGA_VS = ~VS_POL, and the latched mode = 0.
REQ-036 Reset assertion mid-frame SHALL take effect immediately, without waiting for a clock.
REQ-037 After release, counting restarts from (0,0) and the first pix_en occurs on the CLK_DIV-th rising edge.

Verification
Small config: H 4/1/2/1, V 3/1/1/1, CLK_DIV=2, POL=1.
REQ-038 Line timing: reset, then run -> HS high for exactly 4 CLOCK_50 cycles every 16; BLANK_N high 8 cycles per active line.
REQ-039 Frame timing -> VS high for 16 cycles every 96; FRAME_START pulses every 96 cycles.
REQ-040 Addressing: MODE=0, FB_DATA = 0x00 & FB_ADDR -> FB_ADDR sequence 0..11 then 0; VGA_B shows 0..11 in order; output lags address by 2 pixels.
REQ-041 Bars: MODE=1 with H_ACTIVE=8 -> per line, RGB = 000, 00F, 0F0, 0FF, F00, F0F, FF0, FFF (component all-ones shown as F).
REQ-042 Mode latch: MODE switched 0->2 mid-frame -> current frame stays framebuffer; the next frame is a checkerboard from pixel (0,0).
REQ-043 Reset: RESET_N pulsed low mid-line for 1 ns between clock edges -> outputs go to the reset values immediately; first pixel after release reads address 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// VGA raster timing generator: a CLOCK_50 divider produces pix_en, counters and the
// framebuffer address form stage one, colour/sync/blank registers form the output stage.
module vga_timing_gen #(
    parameter int H_ACTIVE = 200,
    parameter int H_FP     = 10,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 22,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CLK_DIV  = 5,
    parameter int ADDR_W   = 17,
    parameter int PIXEL_W  = 24
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET_N,
    input  logic [1:0]             MODE,
    output logic [ADDR_W-1:0]      FB_ADDR,
    input  logic [PIXEL_W-1:0]     FB_DATA,
    output logic [PIXEL_W/3-1:0]   VGA_R,
    output logic [PIXEL_W/3-1:0]   VGA_G,
    output logic [PIXEL_W/3-1:0]   VGA_B,
    output logic                   VGA_HS,
    output logic                   VGA_VS,
    output logic                   VGA_BLANK_N,
    output logic                   VGA_SYNC_N,
    output logic                   VGA_CLK,
    output logic                   FRAME_START
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Counters are at least 4 bits wide so the checkerboard can always use bit 3.
    localparam int HW = ($clog2(H_TOTAL + 1) > 4) ? $clog2(H_TOTAL + 1) : 4;
    localparam int VW = ($clog2(V_TOTAL + 1) > 4) ? $clog2(V_TOTAL + 1) : 4;
    localparam int DW = $clog2(CLK_DIV);
    localparam int CW = PIXEL_W / 3;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    localparam logic [1:0] MODE_FB    = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;

    logic [DW-1:0]     div_cnt, div_next;
    logic              pix_en;
    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic              active, hs_on, vs_on, frame_wrap, first_pos;
    logic [2:0]        bar_idx;
    logic [1:0]        mode_lat;

    logic              a_active, a_hs, a_vs, a_chk, a_first;
    logic [2:0]        a_bar;
    logic [PIXEL_W-1:0] a_data;
    logic [CW-1:0]     r_n, g_n, b_n;

    // Bar boundary k is the first column whose (h*8)/H_ACTIVE reaches k.
    function automatic logic [HW-1:0] bar_thr(input int k);
        return HW'((k * H_ACTIVE + 7) / 8);
    endfunction

    assign pix_en     = (div_cnt == DIV_LAST);
    assign div_next   = pix_en ? '0 : div_cnt + DW'(1);
    assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_on      = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_on      = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign frame_wrap = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign first_pos  = (h_cnt == '0) && (v_cnt == '0);
    assign FB_ADDR    = addr_cnt;
    assign VGA_SYNC_N = 1'b0;

    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_cnt >= bar_thr(k)) bar_idx = bar_idx + 3'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            div_cnt <= '0;
            VGA_CLK <= 1'b0;
        end else begin
            div_cnt <= div_next;
            VGA_CLK <= (div_next >= DIV_HALF);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            addr_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
            // The address only moves past active pixels and folds back after the last one.
            if (frame_wrap)
                addr_cnt <= '0;
            else if (active)
                addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + ADDR_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            a_active <= 1'b0;
            a_hs     <= 1'b0;
            a_vs     <= 1'b0;
            a_chk    <= 1'b0;
            a_first  <= 1'b0;
            a_bar    <= 3'd0;
            a_data   <= '0;
            mode_lat <= 2'd0;
        end else if (pix_en) begin
            a_active <= active;
            a_hs     <= hs_on;
            a_vs     <= vs_on;
            a_chk    <= h_cnt[3] ^ v_cnt[3];
            a_first  <= first_pos;
            a_bar    <= bar_idx;
            a_data   <= FB_DATA;
            if (first_pos) mode_lat <= MODE;
        end
    end

    always_comb begin
        r_n = '0;
        g_n = '0;
        b_n = '0;
        if (a_active) begin
            case (mode_lat)
                MODE_FB:    {r_n, g_n, b_n} = a_data;
                MODE_BARS: begin
                    r_n = {CW{a_bar[2]}};
                    g_n = {CW{a_bar[1]}};
                    b_n = {CW{a_bar[0]}};
                end
                MODE_CHECK: begin
                    r_n = {CW{a_chk}};
                    g_n = {CW{a_chk}};
                    b_n = {CW{a_chk}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            VGA_BLANK_N <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            FRAME_START <= pix_en && a_first;
            if (pix_en) begin
                VGA_R       <= r_n;
                VGA_G       <= g_n;
                VGA_B       <= b_n;
                VGA_HS      <= a_hs ? HS_POL : ~HS_POL;
                VGA_VS      <= a_vs ? VS_POL : ~VS_POL;
                VGA_BLANK_N <= a_active;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen: a small and a wider configuration run side by side and are
// compared every cycle against an arithmetic raster model driven by the edge count.
module tb_vga_timing_gen;
    localparam int S_HA = 4,  S_HFP = 1, S_HS = 2, S_HBP = 1;
    localparam int S_VA = 3,  S_VFP = 1, S_VS = 1, S_VBP = 1, S_DIV = 2;
    localparam int W_HA = 20, W_HFP = 2, W_HS = 3, W_HBP = 3;
    localparam int W_VA = 10, W_VFP = 1, W_VS = 2, W_VBP = 1, W_DIV = 3;

    typedef struct packed {
        int ha; int hfp; int hs; int hbp;
        int va; int vfp; int vs; int vbp;
        int div; int hpol; int vpol; int pw;
    } cfg_t;

    typedef struct packed {
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic        vga_clk;
        logic        frame_start;
        logic [16:0] addr;
    } exp_t;

    localparam cfg_t CFG_S = '{S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, S_DIV, 1, 1, 24};
    localparam cfg_t CFG_W = '{W_HA, W_HFP, W_HS, W_HBP, W_VA, W_VFP, W_VS, W_VBP, W_DIV, 0, 0, 12};

    // clock / reset
    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic [1:0]  mode_s = 2'd0, mode_w = 2'd0;
    logic [16:0] fb_addr_s;
    logic [23:0] fb_data_s = '0;
    logic [7:0]  r_s, g_s, b_s;
    logic        hs_s, vs_s, blank_s, sync_s, vclk_s, fs_s;
    logic [9:0]  fb_addr_w;
    logic [11:0] fb_data_w = '0;
    logic [3:0]  r_w, g_w, b_w;
    logic        hs_w, vs_w, blank_w, sync_w, vclk_w, fs_w;

    logic [11:0] mem_w [0:W_HA*W_VA-1];

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(S_DIV), .ADDR_W(17), .PIXEL_W(24)
    ) dut_s (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .MODE(mode_s),
        .FB_ADDR(fb_addr_s), .FB_DATA(fb_data_s),
        .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s),
        .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(blank_s), .VGA_SYNC_N(sync_s),
        .VGA_CLK(vclk_s), .FRAME_START(fs_s)
    );

    vga_timing_gen #(
        .H_ACTIVE(W_HA), .H_FP(W_HFP), .H_SYNC(W_HS), .H_BP(W_HBP),
        .V_ACTIVE(W_VA), .V_FP(W_VFP), .V_SYNC(W_VS), .V_BP(W_VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(W_DIV), .ADDR_W(10), .PIXEL_W(12)
    ) dut_w (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .MODE(mode_w),
        .FB_ADDR(fb_addr_w), .FB_DATA(fb_data_w),
        .VGA_R(r_w), .VGA_G(g_w), .VGA_B(b_w),
        .VGA_HS(hs_w), .VGA_VS(vs_w), .VGA_BLANK_N(blank_w), .VGA_SYNC_N(sync_w),
        .VGA_CLK(vclk_w), .FRAME_START(fs_w)
    );

    // synchronous framebuffers: one cycle read latency
    always @(posedge CLOCK_50) begin
        fb_data_s <= {7'd0, fb_addr_s};
        fb_data_w <= (fb_addr_w < 10'(W_HA * W_VA)) ? mem_w[fb_addr_w] : 12'd0;
    end

    // reference model
    function automatic int ht(cfg_t c); return c.ha + c.hfp + c.hs + c.hbp; endfunction
    function automatic int vt(cfg_t c); return c.va + c.vfp + c.vs + c.vbp; endfunction
    function automatic int ft(cfg_t c); return ht(c) * vt(c); endfunction

    function automatic int addr_at(cfg_t c, int q);
        int h, v, a;
        h = q % ht(c);
        v = q / ht(c);
        a = v * c.ha + ((h < c.ha) ? h : c.ha);
        return (a >= c.ha * c.va) ? 0 : a;
    endfunction

    function automatic exp_t model(cfg_t c, int e, logic [1:0] md, int d);
        exp_t x;
        int p, q, h, v, cw, ones, bar;
        x = '0;
        cw = c.pw / 3;
        ones = (1 << cw) - 1;
        p = e / c.div;
        x.vga_clk = ((e % c.div) >= c.div / 2);
        x.addr = 17'(addr_at(c, p % ft(c)));
        x.hs = (c.hpol == 0);
        x.vs = (c.vpol == 0);
        if (p >= 2) begin
            q = (p - 2) % ft(c);
            h = q % ht(c);
            v = q / ht(c);
            x.frame_start = (q == 0) && (e % c.div == 0);
            if (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) x.hs = (c.hpol != 0);
            if (v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) x.vs = (c.vpol != 0);
            if (h < c.ha && v < c.va) begin
                x.blank_n = 1'b1;
                case (md)
                    2'd0: begin
                        x.r = 8'((d >> (2 * cw)) & ones);
                        x.g = 8'((d >> cw) & ones);
                        x.b = 8'(d & ones);
                    end
                    2'd1: begin
                        bar = (h * 8) / c.ha;
                        x.r = ((bar / 4) % 2 == 1) ? 8'(ones) : 8'd0;
                        x.g = ((bar / 2) % 2 == 1) ? 8'(ones) : 8'd0;
                        x.b = (bar % 2 == 1) ? 8'(ones) : 8'd0;
                    end
                    2'd2: begin
                        if ((h / 8) % 2 != (v / 8) % 2) begin
                            x.r = 8'(ones);
                            x.g = 8'(ones);
                            x.b = 8'(ones);
                        end
                    end
                    default: ;
                endcase
            end
        end
        return x;
    endfunction

    // edge count since reset release and the mode each frame latched
    int         e_cnt = 0;
    logic [1:0] modes_s [64];
    logic [1:0] modes_w [64];

    always @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            e_cnt = 0;
        end else begin
            e_cnt = e_cnt + 1;
            if (e_cnt % S_DIV == 0 && ((e_cnt / S_DIV - 1) % ft(CFG_S)) == 0)
                modes_s[((e_cnt / S_DIV - 1) / ft(CFG_S)) % 64] = mode_s;
            if (e_cnt % W_DIV == 0 && ((e_cnt / W_DIV - 1) % ft(CFG_W)) == 0)
                modes_w[((e_cnt / W_DIV - 1) / ft(CFG_W)) % 64] = mode_w;
        end
    end

    // scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_small();
        exp_t x;
        int p, q, d;
        logic [1:0] md;
        p = e_cnt / S_DIV;
        md = 2'd0;
        d = 0;
        if (p >= 2) begin
            q = (p - 2) % ft(CFG_S);
            md = modes_s[((p - 2) / ft(CFG_S)) % 64];
            d = addr_at(CFG_S, q);
        end
        x = model(CFG_S, e_cnt, md, d);
        check_eq("s_addr",  32'(fb_addr_s), 32'(x.addr));
        check_eq("s_r",     32'(r_s),       32'(x.r));
        check_eq("s_g",     32'(g_s),       32'(x.g));
        check_eq("s_b",     32'(b_s),       32'(x.b));
        check_eq("s_hs",    32'(hs_s),      32'(x.hs));
        check_eq("s_vs",    32'(vs_s),      32'(x.vs));
        check_eq("s_blank", 32'(blank_s),   32'(x.blank_n));
        check_eq("s_vclk",  32'(vclk_s),    32'(x.vga_clk));
        check_eq("s_fs",    32'(fs_s),      32'(x.frame_start));
        check_eq("s_sync",  32'(sync_s),    32'd0);
    endtask

    task automatic check_wide();
        exp_t x;
        int p, q, d;
        logic [1:0] md;
        p = e_cnt / W_DIV;
        md = 2'd0;
        d = 0;
        if (p >= 2) begin
            q = (p - 2) % ft(CFG_W);
            md = modes_w[((p - 2) / ft(CFG_W)) % 64];
            d = int'(mem_w[addr_at(CFG_W, q)]);
        end
        x = model(CFG_W, e_cnt, md, d);
        check_eq("w_addr",  32'(fb_addr_w), 32'(x.addr));
        check_eq("w_r",     32'(r_w),       32'(x.r));
        check_eq("w_g",     32'(g_w),       32'(x.g));
        check_eq("w_b",     32'(b_w),       32'(x.b));
        check_eq("w_hs",    32'(hs_w),      32'(x.hs));
        check_eq("w_vs",    32'(vs_w),      32'(x.vs));
        check_eq("w_blank", 32'(blank_w),   32'(x.blank_n));
        check_eq("w_vclk",  32'(vclk_w),    32'(x.vga_clk));
        check_eq("w_fs",    32'(fs_w),      32'(x.frame_start));
        check_eq("w_sync",  32'(sync_w),    32'd0);
    endtask

    always @(negedge CLOCK_50) begin
        if (chk_on) begin
            check_small();
            check_wide();
        end
    end

    // directed line/frame budget of the small raster: 16-cycle lines, 96-cycle frames
    task automatic measure_frame_s();
        int guard, hs_n, vs_n, bl_n, fs_n;
        guard = 0;
        while (fs_s !== 1'b1 && guard < 200) begin
            @(negedge CLOCK_50);
            guard++;
        end
        check_eq("s_fs_seen", 32'(fs_s), 32'd1);
        hs_n = 0; vs_n = 0; bl_n = 0; fs_n = 0;
        for (int i = 0; i < 96; i++) begin
            if (hs_s)    hs_n++;
            if (vs_s)    vs_n++;
            if (blank_s) bl_n++;
            if (fs_s)    fs_n++;
            @(negedge CLOCK_50);
        end
        check_eq("s_hs_cycles",    32'(hs_n), 32'd24);
        check_eq("s_vs_cycles",    32'(vs_n), 32'd16);
        check_eq("s_blank_cycles", 32'(bl_n), 32'd24);
        check_eq("s_fs_pulses",    32'(fs_n), 32'd1);
        check_eq("s_fs_period",    32'(fs_s), 32'd1);
    endtask

    task automatic random_modes(input int n);
        repeat (n) begin
            repeat ($urandom_range(30, 900)) @(negedge CLOCK_50);
            mode_s = 2'($urandom_range(0, 3));
            mode_w = 2'($urandom_range(0, 3));
        end
    endtask

    // driver
    initial begin
        int guard;
        for (int i = 0; i < W_HA * W_VA; i++) mem_w[i] = 12'($urandom_range(0, 4095));
        for (int i = 0; i < 64; i++) begin
            modes_s[i] = 2'd0;
            modes_w[i] = 2'd0;
        end
        RESET_N = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        chk_on = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;

        measure_frame_s();

        // each source in turn, switched mid-frame
        for (int m = 0; m < 4; m++) begin
            mode_s = 2'(m);
            mode_w = 2'(m);
            repeat (1300) @(negedge CLOCK_50);
        end
        mode_s = 2'd0;
        repeat (150) @(negedge CLOCK_50);
        mode_s = 2'd2;
        repeat (200) @(negedge CLOCK_50);
        random_modes(12);

        // short asynchronous reset pulse in the middle of an active line
        guard = 0;
        while (blank_s !== 1'b1 && guard < 200) begin
            @(negedge CLOCK_50);
            guard++;
        end
        check_eq("s_active_before_rst", 32'(blank_s), 32'd1);
        #1 RESET_N = 1'b0;
        #0.5;
        check_small();
        check_wide();
        #0.5 RESET_N = 1'b1;

        measure_frame_s();
        random_modes(6);
        repeat (20) @(negedge CLOCK_50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
